pg_sched: RTL and testbench

Epsilon-greedy scheduler for the policy generator (PG) in the Q-learning datapath. It accepts one Q-vector per step and drives PG's `Asel`, `Arand` and `learning` inputs, aligned to PG's internal register stages. It flags when PG's output action `A` is valid and counts steps and episodes. It also decays epsilon once per episode.

---
 rtl/pg_sched.sv | 182 ++++++++++++++++++
 tb/tb_pg_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_sched.sv
// pg_sched: epsilon-greedy scheduler for the Q-learning policy generator.
// Accepts one Q-vector per step, drives the greedy/random select toward PG
// aligned with its register stages, and tracks steps, episodes and epsilon.
module pg_sched #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic             goal,
    input  logic [15:0]      eps_init,
    input  logic [15:0]      eps_min,
    input  logic [15:0]      eps_decay,
    input  logic [CNT_W-1:0] max_steps,
    input  logic [CNT_W-1:0] max_episodes,
    output logic             Asel,
    output logic [1:0]       Arand,
    output logic             learning,
    output logic             a_valid,
    output logic             ep_done,
    output logic             done,
    output logic [15:0]      epsilon,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] episode_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SEL    = 3'd2,
        ST_ACT    = 3'd3,
        ST_EP_END = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Fibonacci LFSR, taps 16/14/13/11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [15:0]      lfsr_r;
    logic [15:0]      epsilon_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic [CNT_W-1:0] episode_cnt_r;
    logic             asel_r;
    logic [1:0]       arand_r;

    logic [15:0]      lfsr_adv_s;
    logic [CNT_W-1:0] step_next_s;
    logic [CNT_W-1:0] episode_next_s;
    logic [CNT_W-1:0] max_eff_s;
    logic             ep_end_s;
    logic             last_ep_s;
    logic [16:0]      eps_floor_sum_s;
    logic [15:0]      eps_decayed_s;

    assign lfsr_adv_s     = lfsr_advance(lfsr_r);
    assign step_next_s    = step_cnt_r + CNT_ONE;
    assign episode_next_s = episode_cnt_r + CNT_ONE;
    // A zero step limit would end nothing sensible; treat it as a limit of one.
    assign max_eff_s      = (max_steps == CNT_ZERO) ? CNT_ONE : max_steps;
    assign ep_end_s       = goal || (step_next_s >= max_eff_s);
    assign last_ep_s      = (max_episodes != CNT_ZERO) && (episode_next_s == max_episodes);
    // 17-bit sum so a large floor plus decay cannot wrap and let epsilon underflow.
    assign eps_floor_sum_s = {1'b0, eps_min} + {1'b0, eps_decay};
    assign eps_decayed_s   = ({1'b0, epsilon_r} < eps_floor_sum_s) ? eps_min
                                                                   : (epsilon_r - eps_decay);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (q_valid) begin
                        state_s = ST_SEL;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_SEL:  state_s = ST_ACT;
                ST_ACT: begin
                    if (ep_end_s) begin
                        state_s = ST_EP_END;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_EP_END: begin
                    if (last_ep_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: LFSR, select outputs, counters and epsilon; all hold on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r        <= SEED;
            epsilon_r     <= 16'h0000;
            step_cnt_r    <= CNT_ZERO;
            episode_cnt_r <= CNT_ZERO;
            asel_r        <= 1'b0;
            arand_r       <= 2'b00;
        end else if (!abort) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_r        <= SEED;
                        epsilon_r     <= eps_init;
                        step_cnt_r    <= CNT_ZERO;
                        episode_cnt_r <= CNT_ZERO;
                    end
                end
                ST_RUN: begin
                    // Select is registered on accept so it is valid in SEL.
                    if (q_valid) begin
                        lfsr_r  <= lfsr_adv_s;
                        asel_r  <= (lfsr_adv_s >= epsilon_r);
                        arand_r <= lfsr_adv_s[15:14];
                    end
                end
                ST_ACT: begin
                    step_cnt_r <= step_next_s;
                end
                ST_EP_END: begin
                    episode_cnt_r <= episode_next_s;
                    step_cnt_r    <= CNT_ZERO;
                    epsilon_r     <= eps_decayed_s;
                end
                default: begin
                    lfsr_r <= lfsr_r;
                end
            endcase
        end
    end

    assign q_ready     = (state_r == ST_RUN);
    assign learning    = (state_r == ST_RUN) || (state_r == ST_SEL) ||
                         (state_r == ST_ACT) || (state_r == ST_EP_END);
    assign a_valid     = (state_r == ST_ACT);
    assign ep_done     = (state_r == ST_EP_END);
    assign done        = (state_r == ST_DONE);
    assign Asel        = asel_r;
    assign Arand       = arand_r;
    assign epsilon     = epsilon_r;
    assign step_cnt    = step_cnt_r;
    assign episode_cnt = episode_cnt_r;

endmodule

// File: tb/tb_pg_sched.sv
// Self-checking bench for pg_sched: randomized stimulus, transaction-level
// reference model, expectation queues popped by an independent monitor.
module tb_pg_sched;

    localparam int          CNT_W = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             q_valid = 1'b0;
    logic             goal = 1'b0;
    logic [15:0]      eps_init = 16'hFFFF;
    logic [15:0]      eps_min = 16'h0000;
    logic [15:0]      eps_decay = 16'h0000;
    logic [CNT_W-1:0] max_steps = 16'd100;
    logic [CNT_W-1:0] max_episodes = 16'd0;
    logic             q_ready;
    logic             Asel;
    logic [1:0]       Arand;
    logic             learning;
    logic             a_valid;
    logic             ep_done;
    logic             done;
    logic [15:0]      epsilon;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] episode_cnt;

    pg_sched #(.SEED(SEED), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .q_valid(q_valid), .q_ready(q_ready), .goal(goal),
        .eps_init(eps_init), .eps_min(eps_min), .eps_decay(eps_decay),
        .max_steps(max_steps), .max_episodes(max_episodes),
        .Asel(Asel), .Arand(Arand), .learning(learning),
        .a_valid(a_valid), .ep_done(ep_done), .done(done),
        .epsilon(epsilon), .step_cnt(step_cnt), .episode_cnt(episode_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic asel; logic [1:0] arand; int step_before; int cyc; } act_t;
    typedef struct { int eps_before; int ep_before; int steps; int cyc; } ep_t;
    act_t act_q[$];
    ep_t  ep_q[$];

    // Reference model state (transaction level).
    logic [15:0] m_lfsr = SEED;
    int m_eps = 0;
    int m_steps = 0;
    int m_epcnt = 0;
    bit m_active = 0;
    bit m_done_pending = 0;
    int m_next_ready = 0;
    int m_act_cyc = -1;
    bit m_goal_plan = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Model one accepted step issued at the current cycle.
    task automatic model_accept(input bit g);
        act_t a;
        ep_t  e;
        int   lim;
        int   nv;
        m_lfsr = lfsr_step(m_lfsr);
        a.asel = (int'(m_lfsr) >= m_eps);
        a.arand = 2'(int'(m_lfsr) / 16384);
        a.step_before = m_steps;
        a.cyc = cyc + 2;
        act_q.push_back(a);
        m_act_cyc = cyc + 2;
        m_goal_plan = g;
        m_steps++;
        lim = (int'(max_steps) == 0) ? 1 : int'(max_steps);
        if (g || m_steps >= lim) begin
            e.eps_before = m_eps;
            e.ep_before = m_epcnt;
            e.steps = m_steps;
            e.cyc = cyc + 3;
            ep_q.push_back(e);
            nv = m_eps - int'(eps_decay);
            m_eps = (nv < int'(eps_min)) ? int'(eps_min) : nv;
            m_epcnt++;
            m_steps = 0;
            if (int'(max_episodes) != 0 && m_epcnt == int'(max_episodes)) begin
                m_done_pending = 1;
                m_next_ready = 1 << 30;
            end else begin
                m_next_ready = cyc + 4;
            end
        end else begin
            m_next_ready = cyc + 3;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        q_valid = 1'b0;
        goal = 1'b0;
        if (!m_active || m_done_pending) begin
            m_eps = int'(eps_init);
            m_steps = 0;
            m_epcnt = 0;
            m_lfsr = SEED;
            m_active = 1;
            m_done_pending = 0;
            m_next_ready = cyc + 1;
        end
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        start = 1'b0;
        q_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        m_active = 0;
        m_done_pending = 0;
    endtask

    task automatic run_phase(input int n, input int qv_pct, input int goal_pct, input int start_pct);
        bit exp_ready;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_ready = m_active && (cyc >= m_next_ready);
            chk("q_ready", 32'(q_ready), 32'(exp_ready));
            if (cyc == m_act_cyc) goal = m_goal_plan;
            else goal = 1'($urandom_range(0, 1));
            start = (m_active && !m_done_pending && ($urandom_range(0, 99) < start_pct));
            q_valid = ($urandom_range(0, 99) < qv_pct);
            if (q_valid && exp_ready)
                model_accept($urandom_range(0, 99) < goal_pct);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_Asel"}, 32'(Asel), 32'(0));
        chk({tag, "_Arand"}, 32'(Arand), 32'(0));
        chk({tag, "_learning"}, 32'(learning), 32'(0));
        chk({tag, "_q_ready"}, 32'(q_ready), 32'(0));
        chk({tag, "_a_valid"}, 32'(a_valid), 32'(0));
        chk({tag, "_ep_done"}, 32'(ep_done), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_epsilon"}, 32'(epsilon), 32'(0));
        chk({tag, "_step_cnt"}, 32'(step_cnt), 32'(0));
        chk({tag, "_episode_cnt"}, 32'(episode_cnt), 32'(0));
    endtask

    // Monitor: pops expectations whenever the DUT presents a_valid / ep_done.
    always @(negedge clk) begin
        if (rst) begin
            if (a_valid) begin
                chk("a_valid_expected", 32'(act_q.size() > 0), 32'(1));
                if (act_q.size() > 0) begin
                    act_t a;
                    a = act_q.pop_front();
                    chk("a_valid_cycle", 32'(cyc), 32'(a.cyc));
                    chk("Asel", 32'(Asel), 32'(a.asel));
                    chk("Arand", 32'(Arand), 32'(a.arand));
                    chk("step_cnt_act", 32'(step_cnt), 32'(a.step_before));
                end
            end else if (act_q.size() > 0 && act_q[0].cyc <= cyc) begin
                chk("a_valid_missing", 32'(a_valid), 32'(1));
                void'(act_q.pop_front());
            end
            if (ep_done) begin
                chk("ep_done_expected", 32'(ep_q.size() > 0), 32'(1));
                if (ep_q.size() > 0) begin
                    ep_t e;
                    e = ep_q.pop_front();
                    chk("ep_done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("epsilon_ep", 32'(epsilon), 32'(e.eps_before));
                    chk("episode_cnt_ep", 32'(episode_cnt), 32'(e.ep_before));
                    chk("step_cnt_ep", 32'(step_cnt), 32'(e.steps));
                end
            end else if (ep_q.size() > 0 && ep_q[0].cyc <= cyc) begin
                chk("ep_done_missing", 32'(ep_done), 32'(1));
                void'(ep_q.pop_front());
            end
        end
    end

    initial begin
        logic       ea;
        logic [1:0] er;

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // Single step, epsilon ~1.0.
        do_start();
        run_phase(1, 100, 0, 0);
        run_phase(6, 0, 0, 0);
        do_abort();

        // Epsilon 0: always greedy, Arand from reference LFSR.
        eps_init = 16'h0000;
        max_steps = 16'd1000;
        do_start();
        run_phase(80, 50, 0, 0);
        run_phase(4, 0, 0, 0);
        do_abort();

        // Decay saturation, four one-step episodes then DONE.
        eps_init = 16'h0300; eps_decay = 16'h0200; eps_min = 16'h0080;
        max_steps = 16'd1; max_episodes = 16'd4;
        do_start();
        run_phase(40, 100, 0, 0);
        chk("decay_done", 32'(done), 32'(1));
        chk("decay_episode_cnt", 32'(episode_cnt), 32'(4));
        chk("decay_epsilon", 32'(epsilon), 32'(16'h0080));
        chk("decay_learning", 32'(learning), 32'(0));

        // Restart from DONE; random goal with max_steps 3 and random decay params.
        eps_init = 16'($urandom); eps_min = 16'($urandom); eps_decay = 16'($urandom);
        max_steps = 16'd3; max_episodes = 16'd0;
        do_start();
        run_phase(200, 70, 40, 0);
        run_phase(5, 0, 0, 0);
        do_abort();

        // max_steps 0 acts as 1.
        eps_init = 16'h4000; eps_decay = 16'h1000; eps_min = 16'h0800;
        max_steps = 16'd0; max_episodes = 16'd3;
        do_start();
        run_phase(30, 100, 0, 0);
        chk("ms0_done", 32'(done), 32'(1));
        chk("ms0_episode_cnt", 32'(episode_cnt), 32'(3));

        // Continuous q_valid with stray start pulses (restart from DONE).
        eps_init = 16'h8000; eps_decay = 16'h0100; eps_min = 16'h0000;
        max_steps = 16'd5; max_episodes = 16'd0;
        do_start();
        run_phase(60, 100, 0, 20);
        run_phase(5, 0, 0, 0);

        // Abort during SEL.
        @(negedge clk);
        start = 1'b0;
        chk("abort_pre_ready", 32'(q_ready), 32'(m_active && (cyc >= m_next_ready)));
        q_valid = 1'b1;
        goal = 1'b0;
        m_lfsr = lfsr_step(m_lfsr);
        ea = (int'(m_lfsr) >= m_eps);
        er = 2'(int'(m_lfsr) / 16384);
        @(negedge clk);
        q_valid = 1'b0;
        abort = 1'b1;
        chk("abort_sel_Asel", 32'(Asel), 32'(ea));
        chk("abort_sel_Arand", 32'(Arand), 32'(er));
        chk("abort_sel_learning", 32'(learning), 32'(1));
        @(negedge clk);
        abort = 1'b0;
        chk("abort_learning", 32'(learning), 32'(0));
        chk("abort_q_ready", 32'(q_ready), 32'(0));
        chk("abort_step_cnt", 32'(step_cnt), 32'(m_steps));
        chk("abort_episode_cnt", 32'(episode_cnt), 32'(m_epcnt));
        chk("abort_epsilon", 32'(epsilon), 32'(m_eps));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_a_valid", 32'(a_valid), 32'(0));
        end
        m_active = 0;

        // Asynchronous reset mid-ACT.
        max_steps = 16'd100;
        do_start();
        run_phase(1, 100, 0, 0);
        @(negedge clk);
        goal = 1'b0;
        q_valid = 1'b0;
        @(negedge clk);
        chk("rst_act_a_valid", 32'(a_valid), 32'(1));
        #1 rst = 1'b0;
        #1 check_reset("async_rst");
        act_q.delete();
        ep_q.delete();
        m_active = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_q_ready", 32'(q_ready), 32'(0));
        chk("post_rst_learning", 32'(learning), 32'(0));

        chk("act_queue_empty", 32'(act_q.size()), 32'(0));
        chk("ep_queue_empty", 32'(ep_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
